// File: rtl/rv32_hazard_pkg.sv
// Shared types for the EX-stage hazard/forwarding unit of the RV32I pipeline.
//   fwd_sel_e  - encoding of the operand Mux3 select (11 is never produced)
//   hz_entry_t - one shadow-pipeline tag entry tracking a single instruction
//   BUBBLE     - an empty entry (valid=0, all fields cleared)
//   fwd_pick   - forwarding source for one EX operand given the MEM/WB entries
package rv32_hazard_pkg;

    localparam int HZ_REG_AW = 5;

    typedef enum logic [1:0] {
        FWD_RF  = 2'b00,
        FWD_WB  = 2'b01,
        FWD_MEM = 2'b10
    } fwd_sel_e;

    typedef struct packed {
        logic                 valid;
        logic [HZ_REG_AW-1:0] rd;
        logic                 we;
        logic                 is_load;
        logic [HZ_REG_AW-1:0] rs1;
        logic [HZ_REG_AW-1:0] rs2;
        logic                 use1;
        logic                 use2;
    } hz_entry_t;

    localparam hz_entry_t BUBBLE = '0;

    // True when the entry will architecturally write a non-x0 register.
    function automatic logic writes_reg(input hz_entry_t e);
        return e.valid & e.we & (e.rd != '0);
    endfunction

    // MEM is checked first so the youngest producer wins. A load sitting in
    // MEM has no data yet, so it is never a MEM-stage forwarding source.
    function automatic fwd_sel_e fwd_pick(input hz_entry_t ex_e,
                                          input hz_entry_t mem_e,
                                          input hz_entry_t wb_e,
                                          input logic      pick_rs2);
        logic [HZ_REG_AW-1:0] src;
        logic                 src_used;
        fwd_sel_e             sel;
        src      = pick_rs2 ? ex_e.rs2  : ex_e.rs1;
        src_used = pick_rs2 ? ex_e.use2 : ex_e.use1;
        sel      = FWD_RF;
        if (ex_e.valid && src_used) begin
            if (writes_reg(mem_e) && !mem_e.is_load && mem_e.rd == src) begin
                sel = FWD_MEM;
            end else if (writes_reg(wb_e) && wb_e.rd == src) begin
                sel = FWD_WB;
            end
        end
        return sel;
    endfunction

endpackage

// File: rtl/hazard_tag_pipe.sv
// Shadow tag pipeline: EX/MEM/WB entry registers mirroring the datapath.
// Ports:
//   clk, rst_n      pipeline clock, async active-low reset (all entries -> BUBBLE)
//   freeze          hold every stage (global memory stall)
//   bubble_ex       load BUBBLE into EX instead of the ID entry
//   id_entry        entry describing the instruction currently in ID
//   ex_entry, mem_entry, wb_entry   current stage contents
module hazard_tag_pipe
    import rv32_hazard_pkg::*;
(
    input  logic      clk,
    input  logic      rst_n,
    input  logic      freeze,
    input  logic      bubble_ex,
    input  hz_entry_t id_entry,
    output hz_entry_t ex_entry,
    output hz_entry_t mem_entry,
    output hz_entry_t wb_entry
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_entry  <= BUBBLE;
            mem_entry <= BUBBLE;
            wb_entry  <= BUBBLE;
        end else if (!freeze) begin
            wb_entry  <= mem_entry;
            mem_entry <= ex_entry;
            ex_entry  <= bubble_ex ? BUBBLE : id_entry;
        end
    end

endmodule

// File: rtl/hazard_fwd_unit.sv
// Hazard and forwarding unit for the EX-stage operand muxes.
// Ports:
//   clk, rst_n                 pipeline clock, async active-low reset
//   id_valid, id_rs1, id_rs2   ID instruction and its source registers
//   id_use_rs1, id_use_rs2     ID instruction actually reads rs1/rs2
//   id_rd, id_reg_write        ID destination and write enable
//   id_mem_read                ID instruction is a load
//   ex_branch_taken            EX redirect (taken branch/jump)
//   mem_stall                  global freeze from data memory
//   fwd_a_sel, fwd_b_sel       operand Mux3 selects: 00 regfile, 01 WB, 10 MEM
//   stall_if, stall_id         hold PC / IF-ID register
//   flush_id, flush_ex         bubble IF-ID / ID-EX
//   stall_cnt, flush_cnt       saturating load-use stall / branch flush counters
module hazard_fwd_unit
    import rv32_hazard_pkg::*;
#(
    parameter int REG_AW = HZ_REG_AW,
    parameter int CNT_W  = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_rs1,
    input  logic [REG_AW-1:0] id_rs2,
    input  logic              id_use_rs1,
    input  logic              id_use_rs2,
    input  logic [REG_AW-1:0] id_rd,
    input  logic              id_reg_write,
    input  logic              id_mem_read,
    input  logic              ex_branch_taken,
    input  logic              mem_stall,
    output logic [1:0]        fwd_a_sel,
    output logic [1:0]        fwd_b_sel,
    output logic              stall_if,
    output logic              stall_id,
    output logic              flush_id,
    output logic              flush_ex,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  flush_cnt
);

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    hz_entry_t id_entry;
    hz_entry_t ex_entry;
    hz_entry_t mem_entry;
    hz_entry_t wb_entry;
    logic      load_use;
    logic      bubble_ex;
    logic      take_flush;
    logic      take_stall;
    fwd_sel_e  fwd_a;
    fwd_sel_e  fwd_b;

    always_comb begin
        id_entry         = BUBBLE;
        id_entry.valid   = id_valid;
        id_entry.rd      = id_rd;
        id_entry.we      = id_reg_write;
        id_entry.is_load = id_mem_read;
        id_entry.rs1     = id_rs1;
        id_entry.rs2     = id_rs2;
        id_entry.use1    = id_use_rs1;
        id_entry.use2    = id_use_rs2;
    end

    // The loaded value is only available from WB, so a reader directly
    // behind a load must wait one cycle.
    assign load_use = ex_entry.is_load & writes_reg(ex_entry) & id_valid &
                      ((id_use_rs1 & (id_rs1 == ex_entry.rd)) |
                       (id_use_rs2 & (id_rs2 == ex_entry.rd)));

    // A redirect wipes the ID instruction anyway, so the load-use check is
    // irrelevant on that cycle.
    assign take_flush = !mem_stall & ex_branch_taken;
    assign take_stall = !mem_stall & !ex_branch_taken & load_use;
    assign bubble_ex  = take_flush | take_stall;

    hazard_tag_pipe u_tag_pipe (
        .clk       (clk),
        .rst_n     (rst_n),
        .freeze    (mem_stall),
        .bubble_ex (bubble_ex),
        .id_entry  (id_entry),
        .ex_entry  (ex_entry),
        .mem_entry (mem_entry),
        .wb_entry  (wb_entry)
    );

    assign fwd_a     = fwd_pick(ex_entry, mem_entry, wb_entry, 1'b0);
    assign fwd_b     = fwd_pick(ex_entry, mem_entry, wb_entry, 1'b1);
    assign fwd_a_sel = fwd_a;
    assign fwd_b_sel = fwd_b;

    // Controls are forced low while reset is asserted so that a reset landing
    // in the middle of a stall releases the pipeline immediately.
    always_comb begin
        stall_if = 1'b0;
        stall_id = 1'b0;
        flush_id = 1'b0;
        flush_ex = 1'b0;
        if (rst_n) begin
            if (mem_stall) begin
                stall_if = 1'b1;
                stall_id = 1'b1;
            end else if (ex_branch_taken) begin
                flush_id = 1'b1;
                flush_ex = 1'b1;
            end else if (load_use) begin
                stall_if = 1'b1;
                stall_id = 1'b1;
                flush_ex = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (take_flush && flush_cnt != '1) begin
                flush_cnt <= flush_cnt + CNT_ONE;
            end
            if (take_stall && stall_cnt != '1) begin
                stall_cnt <= stall_cnt + CNT_ONE;
            end
        end
    end

    // Source fields of older stages are never compared against.
    logic unused_tag_bits;
    assign unused_tag_bits = ^{mem_entry.rs1, mem_entry.rs2, mem_entry.use1, mem_entry.use2,
                               wb_entry.rs1, wb_entry.rs2, wb_entry.use1, wb_entry.use2,
                               wb_entry.is_load};

endmodule

// File: tb/tb_hazard_fwd_unit.sv
module tb_hazard_fwd_unit;

    localparam int CNT_W = 4;
    localparam int CMAX  = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             id_valid;
    logic [4:0]       id_rs1, id_rs2, id_rd;
    logic             id_use_rs1, id_use_rs2;
    logic             id_reg_write, id_mem_read;
    logic             ex_branch_taken, mem_stall;
    logic [1:0]       fwd_a_sel, fwd_b_sel;
    logic             stall_if, stall_id, flush_id, flush_ex;
    logic [CNT_W-1:0] stall_cnt, flush_cnt;

    always #5 clk = ~clk;

    hazard_fwd_unit #(.REG_AW(5), .CNT_W(CNT_W)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .id_valid        (id_valid),
        .id_rs1          (id_rs1),
        .id_rs2          (id_rs2),
        .id_use_rs1      (id_use_rs1),
        .id_use_rs2      (id_use_rs2),
        .id_rd           (id_rd),
        .id_reg_write    (id_reg_write),
        .id_mem_read     (id_mem_read),
        .ex_branch_taken (ex_branch_taken),
        .mem_stall       (mem_stall),
        .fwd_a_sel       (fwd_a_sel),
        .fwd_b_sel       (fwd_b_sel),
        .stall_if        (stall_if),
        .stall_id        (stall_id),
        .flush_id        (flush_id),
        .flush_ex        (flush_ex),
        .stall_cnt       (stall_cnt),
        .flush_cnt       (flush_cnt)
    );

    // Reference model: instructions in flight, index 0=EX, 1=MEM, 2=WB.
    typedef struct {
        bit v;
        int rd;
        bit we;
        bit ld;
        int rs1;
        int rs2;
        bit u1;
        bit u2;
    } instr_t;

    instr_t stg[3];
    int     m_stall_cnt, m_flush_cnt;
    int     n_checks = 0;
    int     n_fail   = 0;
    int     obs_stall_if, obs_stall_id, obs_flush_id, obs_flush_ex;

    task automatic check_eq(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 3; i++) stg[i] = '{default: 0};
        m_stall_cnt = 0;
        m_flush_cnt = 0;
    endtask

    function automatic bit produces(input instr_t p, input int r);
        return p.v && p.we && p.rd != 0 && p.rd == r;
    endfunction

    function automatic int m_fwd(input bit second);
        int src;
        bit used;
        src  = second ? stg[0].rs2 : stg[0].rs1;
        used = second ? stg[0].u2  : stg[0].u1;
        if (!stg[0].v || !used) return 0;
        if (produces(stg[1], src) && !stg[1].ld) return 2;
        if (produces(stg[2], src)) return 1;
        return 0;
    endfunction

    // One pipeline cycle: drive ID/control inputs, compare every output with
    // the model, then clock and advance the model.
    task automatic cyc(input bit iv, input int rs1, input int rs2, input bit u1,
                       input bit u2, input int rd, input bit we, input bit ld,
                       input bit br, input bit ms);
        bit     lu;
        int     e_sif, e_sid, e_fid, e_fex;
        instr_t nid;
        id_valid        = iv;
        id_rs1          = rs1[4:0];
        id_rs2          = rs2[4:0];
        id_use_rs1      = u1;
        id_use_rs2      = u2;
        id_rd           = rd[4:0];
        id_reg_write    = we;
        id_mem_read     = ld;
        ex_branch_taken = br;
        mem_stall       = ms;
        #1;
        lu = stg[0].v && stg[0].ld && stg[0].we && stg[0].rd != 0 && iv &&
             ((u1 && rs1 == stg[0].rd) || (u2 && rs2 == stg[0].rd));
        e_sif = 0; e_sid = 0; e_fid = 0; e_fex = 0;
        if (ms) begin
            e_sif = 1; e_sid = 1;
        end else if (br) begin
            e_fid = 1; e_fex = 1;
        end else if (lu) begin
            e_sif = 1; e_sid = 1; e_fex = 1;
        end
        check_eq("fwd_a_sel", int'(fwd_a_sel), m_fwd(1'b0));
        check_eq("fwd_b_sel", int'(fwd_b_sel), m_fwd(1'b1));
        check_eq("stall_if",  int'(stall_if),  e_sif);
        check_eq("stall_id",  int'(stall_id),  e_sid);
        check_eq("flush_id",  int'(flush_id),  e_fid);
        check_eq("flush_ex",  int'(flush_ex),  e_fex);
        check_eq("stall_cnt", int'(stall_cnt), m_stall_cnt);
        check_eq("flush_cnt", int'(flush_cnt), m_flush_cnt);
        obs_stall_if = int'(stall_if);
        obs_stall_id = int'(stall_id);
        obs_flush_id = int'(flush_id);
        obs_flush_ex = int'(flush_ex);
        nid = '{v: iv, rd: rd, we: we, ld: ld, rs1: rs1, rs2: rs2, u1: u1, u2: u2};
        @(posedge clk);
        if (!ms) begin
            stg[2] = stg[1];
            stg[1] = stg[0];
            if (br || lu) stg[0] = '{default: 0};
            else          stg[0] = nid;
            if (br) begin
                if (m_flush_cnt < CMAX) m_flush_cnt++;
            end else if (lu) begin
                if (m_stall_cnt < CMAX) m_stall_cnt++;
            end
        end
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        check_eq({tag, "_fwd_a"},  int'(fwd_a_sel), 0);
        check_eq({tag, "_fwd_b"},  int'(fwd_b_sel), 0);
        check_eq({tag, "_stall_if"}, int'(stall_if), 0);
        check_eq({tag, "_stall_id"}, int'(stall_id), 0);
        check_eq({tag, "_flush_id"}, int'(flush_id), 0);
        check_eq({tag, "_flush_ex"}, int'(flush_ex), 0);
        check_eq({tag, "_stall_cnt"}, int'(stall_cnt), 0);
        check_eq({tag, "_flush_cnt"}, int'(flush_cnt), 0);
    endtask

    initial begin
        rst_n = 1'b0;
        id_valid = 0; id_rs1 = 0; id_rs2 = 0; id_use_rs1 = 0; id_use_rs2 = 0;
        id_rd = 0; id_reg_write = 0; id_mem_read = 0;
        ex_branch_taken = 0; mem_stall = 0;
        model_reset();
        #12;
        check_all_zero("rst");
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // add x5 then sub x6,x5,x2: MEM forward
        cyc(1, 1, 2, 1, 1, 5, 1, 0, 0, 0);
        cyc(1, 5, 2, 1, 1, 6, 1, 0, 0, 0);
        check_eq("dir_fwd_mem", int'(fwd_a_sel), 2);
        // add x9, gap, reader: WB forward
        cyc(1, 1, 2, 1, 1, 9, 1, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        cyc(1, 9, 0, 1, 0, 10, 1, 0, 0, 0);
        check_eq("dir_fwd_wb", int'(fwd_a_sel), 1);

        // lw x7 then add x8,x7,x1: one stall, then WB forward
        cyc(1, 2, 0, 1, 0, 7, 1, 1, 0, 0);
        cyc(1, 7, 1, 1, 1, 8, 1, 0, 0, 0);
        check_eq("lu_stall_if", obs_stall_if, 1);
        check_eq("lu_flush_ex", obs_flush_ex, 1);
        cyc(1, 7, 1, 1, 1, 8, 1, 0, 0, 0);
        check_eq("lu_released", obs_stall_if, 0);
        check_eq("lu_fwd_wb", int'(fwd_a_sel), 1);
        check_eq("lu_stall_cnt", int'(stall_cnt), 1);

        // MEM and WB both write x3, EX reads x3 on rs2: MEM wins
        cyc(1, 1, 1, 0, 0, 3, 1, 0, 0, 0);
        cyc(1, 1, 1, 0, 0, 3, 1, 0, 0, 0);
        cyc(1, 4, 3, 0, 1, 11, 1, 0, 0, 0);
        check_eq("dir_fwd_b_mem", int'(fwd_b_sel), 2);
        // producer with rd=x0 is never forwarded
        cyc(1, 1, 1, 0, 0, 0, 1, 0, 0, 0);
        cyc(1, 0, 4, 1, 0, 12, 1, 0, 0, 0);
        check_eq("dir_x0_fwd", int'(fwd_a_sel), 0);

        // branch together with load-use: flush wins, no stall counted
        cyc(1, 2, 0, 1, 0, 7, 1, 1, 0, 0);
        cyc(1, 7, 1, 1, 1, 8, 1, 0, 1, 0);
        check_eq("br_flush_id", obs_flush_id, 1);
        check_eq("br_flush_ex", obs_flush_ex, 1);
        check_eq("br_stall_if", obs_stall_if, 0);
        check_eq("br_flush_cnt", int'(flush_cnt), 1);
        check_eq("br_stall_cnt", int'(stall_cnt), 1);

        // mem_stall for 3 cycles while forwarding from MEM
        cyc(1, 1, 2, 1, 1, 5, 1, 0, 0, 0);
        cyc(1, 5, 2, 1, 1, 6, 1, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            cyc(1, 5, 5, 1, 1, 13, 1, 0, (i == 1), 1);
            check_eq("ms_fwd_hold", int'(fwd_a_sel), 2);
            check_eq("ms_stall_if", obs_stall_if, 1);
            check_eq("ms_stall_cnt", int'(stall_cnt), 1);
            check_eq("ms_flush_cnt", int'(flush_cnt), 1);
        end
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        check_eq("ms_resume", int'(fwd_a_sel), 0);

        // randomized traffic over a small register set to provoke hazards
        for (int i = 0; i < 600; i++) begin
            cyc(($urandom_range(0, 3) != 0), $urandom_range(0, 3), $urandom_range(0, 3),
                1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom_range(0, 3),
                1'($urandom_range(0, 1)), ($urandom_range(0, 2) == 0),
                ($urandom_range(0, 7) == 0), ($urandom_range(0, 7) == 0));
        end

        // asynchronous reset mid-run, away from a clock edge, with a stall pending
        mem_stall = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        check_all_zero("async_rst");
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // counter saturation
        for (int i = 0; i < CMAX + 3; i++) begin
            cyc(1, 2, 0, 0, 0, 7, 1, 1, 0, 0);
            cyc(1, 7, 1, 1, 0, 8, 1, 0, 0, 0);
            cyc(1, 7, 1, 1, 0, 8, 1, 0, 0, 0);
        end
        check_eq("sat_stall_cnt", int'(stall_cnt), CMAX);
        for (int i = 0; i < CMAX + 3; i++) begin
            cyc(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        end
        check_eq("sat_flush_cnt", int'(flush_cnt), CMAX);
        check_eq("sat_stall_hold", int'(stall_cnt), CMAX);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
